// File: rtl/conv_bram_arbiter_pkg.sv
// Shared constants for the conv BRAM arbiter: pass-FSM encoding and requester IDs.
package conv_bram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic REQ_HOST   = 1'b0;
    localparam logic REQ_ENGINE = 1'b1;

    // Round-robin tie break for two requesters: the side not served last wins.
    function automatic logic rr_host_wins(input logic last_gnt);
        return (last_gnt == REQ_ENGINE);
    endfunction

endpackage

// File: rtl/conv_bram_arbiter.sv
// Single-port BRAM arbiter shared by a host loader and a convolution engine,
// sequenced by a LOAD/RUN/DRAIN/DONE pass FSM.
//
// Handshake: a requester holds req (with we/addr/wdata) until it sees gnt in the
// same cycle; the access is issued to the BRAM in that cycle. A granted read
// returns rvalid/rdata to its owner exactly one cycle later; writes return nothing.
module conv_bram_arbiter
    import conv_bram_arbiter_pkg::*;
#(
    parameter int AXI_ADDR_BW = 8,
    parameter int AXI_DATA_BW = 32
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,

    input  logic                   i_h_req,
    input  logic                   i_h_we,
    input  logic [AXI_ADDR_BW-1:0] i_h_addr,
    input  logic [AXI_DATA_BW-1:0] i_h_wdata,
    output logic                   o_h_gnt,
    output logic                   o_h_rvalid,
    output logic [AXI_DATA_BW-1:0] o_h_rdata,

    input  logic                   i_e_req,
    input  logic                   i_e_we,
    input  logic [AXI_ADDR_BW-1:0] i_e_addr,
    input  logic [AXI_DATA_BW-1:0] i_e_wdata,
    output logic                   o_e_gnt,
    output logic                   o_e_rvalid,
    output logic [AXI_DATA_BW-1:0] o_e_rdata,

    output logic                   o_bram_en,
    output logic                   o_bram_we,
    output logic [AXI_ADDR_BW-1:0] o_bram_addr,
    output logic [AXI_DATA_BW-1:0] o_bram_wdata,
    input  logic [AXI_DATA_BW-1:0] i_bram_rdata,

    input  logic                   i_start,
    input  logic                   i_e_done,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [1:0]             o_dbg_state
);

    state_e state_q, state_d;
    logic   last_gnt_q;
    logic   rd_pend_q;
    logic   rd_owner_q;
    logic   h_gnt, e_gnt;
    logic   rd_issue;

    // Grants are gated by reset so the BRAM port stays quiet while ARESETn is low.
    always_comb begin
        h_gnt = 1'b0;
        e_gnt = 1'b0;
        if (ARESETn) begin
            case (state_q)
                ST_LOAD, ST_DONE: h_gnt = i_h_req;
                ST_RUN: begin
                    if (i_h_req && i_e_req) begin
                        h_gnt = rr_host_wins(last_gnt_q);
                        e_gnt = !rr_host_wins(last_gnt_q);
                    end else begin
                        h_gnt = i_h_req;
                        e_gnt = i_e_req;
                    end
                end
                default: begin
                    h_gnt = 1'b0;
                    e_gnt = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        o_bram_en    = h_gnt | e_gnt;
        o_bram_we    = 1'b0;
        o_bram_addr  = '0;
        o_bram_wdata = '0;
        if (e_gnt) begin
            o_bram_we    = i_e_we;
            o_bram_addr  = i_e_addr;
            o_bram_wdata = i_e_wdata;
        end else if (h_gnt) begin
            o_bram_we    = i_h_we;
            o_bram_addr  = i_h_addr;
            o_bram_wdata = i_h_wdata;
        end
    end

    assign rd_issue = (h_gnt && !i_h_we) || (e_gnt && !i_e_we);

    // In RUN a simultaneous i_e_done beats i_start; in DONE i_start is the only exit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:  if (i_start)    state_d = ST_RUN;
            ST_RUN:   if (i_e_done)   state_d = ST_DRAIN;
            ST_DRAIN: if (!rd_pend_q) state_d = ST_DONE;
            ST_DONE:  if (i_start)    state_d = ST_RUN;
            default:                  state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= ST_LOAD;
            last_gnt_q <= REQ_ENGINE;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= REQ_HOST;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_issue;
            if (h_gnt || e_gnt) begin
                last_gnt_q <= e_gnt ? REQ_ENGINE : REQ_HOST;
            end
            if (rd_issue) begin
                rd_owner_q <= e_gnt ? REQ_ENGINE : REQ_HOST;
            end
        end
    end

    assign o_h_gnt     = h_gnt;
    assign o_e_gnt     = e_gnt;
    assign o_h_rvalid  = rd_pend_q && (rd_owner_q == REQ_HOST);
    assign o_e_rvalid  = rd_pend_q && (rd_owner_q == REQ_ENGINE);
    assign o_h_rdata   = o_h_rvalid ? i_bram_rdata : '0;
    assign o_e_rdata   = o_e_rvalid ? i_bram_rdata : '0;
    assign o_busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign o_done      = (state_q == ST_DONE);
    assign o_dbg_state = state_q;

endmodule
